port_out_hs: RTL and testbench

PORT_OUT_HS -- requirements
Module: port_out_hs

---
 rtl/port_out_hs_if.sv | 24 ++
 rtl/port_out_hs.sv | 89 ++++++++
 tb/tb_port_out_hs.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/port_out_hs_if.sv
// Bus/handshake bundle for port_out_hs: CPU write side plus peripheral pins.
// The CPU/bench drives through master; the port block itself uses slave.
interface port_out_hs_if #(
    parameter int unsigned WIDTH = 8
);
    logic             mode;
    logic             inte;
    logic             ld_n;
    logic [WIDTH-1:0] din;
    logic             ack_n;
    logic [WIDTH-1:0] dout;
    logic             obf_n;
    logic             intr;

    modport master (
        output mode, inte, ld_n, din, ack_n,
        input  dout, obf_n, intr
    );

    modport slave (
        input  mode, inte, ld_n, din, ack_n,
        output dout, obf_n, intr
    );
endinterface

// File: rtl/port_out_hs.sv
// Output port with basic latched mode and a strobed mode that uses an OBF/ACK
// handshake and an acknowledge-driven interrupt.
module port_out_hs #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic          clk,
    input logic          reset,
    port_out_hs_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } hs_state_t;

    hs_state_t        state;
    hs_state_t        state_next;
    logic             intr_q;
    logic             intr_next;
    logic [WIDTH-1:0] dout_q;
    logic             s1;
    logic             s2;
    logic             s3;
    logic             load;
    logic             ack_fall;
    logic             ack_rise;

    assign load     = ~bus.ld_n;
    assign ack_fall = ~s2 & s3;
    assign ack_rise = s2 & ~s3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q <= RESET_VAL;
        end else if (load) begin
            dout_q <= bus.din;
        end
    end

    // s1/s2 resolve metastability on the asynchronous ack_n; s3 only delays for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= bus.ack_n;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            intr_q <= 1'b0;
        end else begin
            state  <= state_next;
            intr_q <= intr_next;
        end
    end

    always_comb begin
        state_next = state;
        intr_next  = intr_q;
        if (!bus.mode) begin
            state_next = IDLE;
            intr_next  = 1'b0;
        end else begin
            // A write outranks a simultaneous acknowledge, which is then lost.
            if (load) begin
                state_next = FULL;
            end else if (ack_fall) begin
                state_next = IDLE;
            end

            // Clear (write or interrupt disable) outranks set.
            if (load || !bus.inte) begin
                intr_next = 1'b0;
            end else if (ack_rise && state == IDLE) begin
                intr_next = 1'b1;
            end
        end
    end

    assign bus.dout  = dout_q;
    assign bus.obf_n = (state == IDLE);
    assign bus.intr  = intr_q;
endmodule

// File: tb/tb_port_out_hs.sv
// Self-checking bench for port_out_hs: vector table fed through a scoreboard,
// plus hand sequences for asynchronous reset and a 16-bit instance.
module tb_port_out_hs;
    logic clk;
    logic reset;

    port_out_hs_if #(.WIDTH(8))  bus8 ();
    port_out_hs_if #(.WIDTH(16)) bus16 ();

    port_out_hs #(.WIDTH(8), .RESET_VAL(8'h00)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    port_out_hs #(.WIDTH(16), .RESET_VAL(16'h8001)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic       inte;
        logic       ld_n;
        logic [7:0] din;
        logic       ack_n;
        logic [7:0] e_dout;
        logic       e_obf_n;
        logic       e_intr;
    } vec_t;

    typedef struct {
        int unsigned idx;
        logic [7:0]  dout;
        logic        obf_n;
        logic        intr;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic m, input logic ie, input logic ld, input logic [7:0] d,
                       input logic ak, input logic [7:0] ed, input logic eo, input logic ei);
        vec_t v;
        v.mode = m; v.inte = ie; v.ld_n = ld; v.din = d; v.ack_n = ak;
        v.e_dout = ed; v.e_obf_n = eo; v.e_intr = ei;
        vecs.push_back(v);
    endtask

    task automatic step(input vec_t v, input int unsigned idx);
        exp_t e;
        exp_t got;
        bus8.mode  = v.mode;
        bus8.inte  = v.inte;
        bus8.ld_n  = v.ld_n;
        bus8.din   = v.din;
        bus8.ack_n = v.ack_n;
        e.idx = idx; e.dout = v.e_dout; e.obf_n = v.e_obf_n; e.intr = v.e_intr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check($sformatf("v%0d scoreboard empty", idx), 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            check($sformatf("v%0d dout", got.idx),  {24'd0, bus8.dout}, {24'd0, got.dout});
            check($sformatf("v%0d obf_n", got.idx), {31'd0, bus8.obf_n}, {31'd0, got.obf_n});
            check($sformatf("v%0d intr", got.idx),  {31'd0, bus8.intr},  {31'd0, got.intr});
        end
    endtask

    initial begin
        reset = 1'b1;
        bus8.mode = 1'b0; bus8.inte = 1'b0; bus8.ld_n = 1'b1; bus8.din = '0; bus8.ack_n = 1'b1;
        bus16.mode = 1'b0; bus16.inte = 1'b0; bus16.ld_n = 1'b1; bus16.din = '0; bus16.ack_n = 1'b1;
        #1;
        check("reset dout",    {24'd0, bus8.dout}, 32'h00);
        check("reset obf_n",   {31'd0, bus8.obf_n}, 32'd1);
        check("reset intr",    {31'd0, bus8.intr}, 32'd0);
        check("reset dout16",  {16'd0, bus16.dout}, 32'h8001);
        @(posedge clk);
        #1;
        reset = 1'b0;

        //   mode inte ld  din    ack   dout  obf intr
        // mode 0: plain latch, ack pulses ignored
        add(0, 0, 0, 8'hA5, 1, 8'hA5, 1, 0);
        add(0, 0, 1, 8'h00, 0, 8'hA5, 1, 0);
        add(0, 0, 1, 8'h00, 0, 8'hA5, 1, 0);
        add(0, 0, 1, 8'h00, 1, 8'hA5, 1, 0);
        add(0, 0, 1, 8'h00, 1, 8'hA5, 1, 0);
        add(0, 0, 1, 8'h00, 1, 8'hA5, 1, 0);
        // mode 1: write, ack low 4 cycles (obf_n high at 3rd edge), intr 3 edges after release
        add(1, 1, 0, 8'h3C, 1, 8'h3C, 0, 0);
        add(1, 1, 1, 8'h00, 0, 8'h3C, 0, 0);
        add(1, 1, 1, 8'h00, 0, 8'h3C, 0, 0);
        add(1, 1, 1, 8'h00, 0, 8'h3C, 1, 0);
        add(1, 1, 1, 8'h00, 0, 8'h3C, 1, 0);
        add(1, 1, 1, 8'h00, 1, 8'h3C, 1, 0);
        add(1, 1, 1, 8'h00, 1, 8'h3C, 1, 0);
        add(1, 1, 1, 8'h00, 1, 8'h3C, 1, 1);
        // write clears intr; inte=0 blocks a full ack pulse
        add(1, 1, 0, 8'h01, 1, 8'h01, 0, 0);
        add(1, 0, 1, 8'h00, 0, 8'h01, 0, 0);
        add(1, 0, 1, 8'h00, 0, 8'h01, 0, 0);
        add(1, 0, 1, 8'h00, 1, 8'h01, 1, 0);
        add(1, 0, 1, 8'h00, 1, 8'h01, 1, 0);
        add(1, 0, 1, 8'h00, 1, 8'h01, 1, 0);
        add(1, 0, 1, 8'h00, 1, 8'h01, 1, 0);
        // ack pulse while idle sets intr; dropping inte clears it
        add(1, 1, 1, 8'h00, 0, 8'h01, 1, 0);
        add(1, 1, 1, 8'h00, 0, 8'h01, 1, 0);
        add(1, 1, 1, 8'h00, 1, 8'h01, 1, 0);
        add(1, 1, 1, 8'h00, 1, 8'h01, 1, 0);
        add(1, 1, 1, 8'h00, 1, 8'h01, 1, 1);
        add(1, 0, 1, 8'h00, 1, 8'h01, 1, 0);
        // write on the ack_fall edge wins; acknowledge is discarded
        add(1, 1, 0, 8'h5A, 1, 8'h5A, 0, 0);
        add(1, 1, 1, 8'h00, 0, 8'h5A, 0, 0);
        add(1, 1, 1, 8'h00, 0, 8'h5A, 0, 0);
        add(1, 1, 0, 8'h66, 0, 8'h66, 0, 0);
        add(1, 1, 1, 8'h00, 0, 8'h66, 0, 0);
        add(1, 1, 1, 8'h00, 1, 8'h66, 0, 0);
        add(1, 1, 1, 8'h00, 1, 8'h66, 0, 0);
        add(1, 1, 1, 8'h00, 1, 8'h66, 0, 0);
        // write coinciding with intr set condition: clear wins
        add(1, 1, 1, 8'h00, 0, 8'h66, 0, 0);
        add(1, 1, 1, 8'h00, 0, 8'h66, 0, 0);
        add(1, 1, 1, 8'h00, 1, 8'h66, 1, 0);
        add(1, 1, 1, 8'h00, 1, 8'h66, 1, 0);
        add(1, 1, 0, 8'h77, 1, 8'h77, 0, 0);
        // mode switches keep dout and return to idle; back-to-back writes
        add(0, 1, 1, 8'h00, 1, 8'h77, 1, 0);
        add(1, 1, 1, 8'h00, 1, 8'h77, 1, 0);
        add(1, 1, 0, 8'h11, 1, 8'h11, 0, 0);
        add(1, 1, 0, 8'h22, 1, 8'h22, 0, 0);
        add(0, 1, 1, 8'h00, 1, 8'h22, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], i);
        end

        // asynchronous reset mid-handshake
        bus8.mode = 1'b1; bus8.inte = 1'b1; bus8.ld_n = 1'b0; bus8.din = 8'hFF;
        @(posedge clk);
        #1;
        check("pre-reset dout",  {24'd0, bus8.dout}, 32'hFF);
        check("pre-reset obf_n", {31'd0, bus8.obf_n}, 32'd0);
        bus8.ld_n = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("async reset dout",  {24'd0, bus8.dout}, 32'h00);
        check("async reset obf_n", {31'd0, bus8.obf_n}, 32'd1);
        check("async reset intr",  {31'd0, bus8.intr}, 32'd0);

        // inputs ignored while reset held
        bus8.ld_n = 1'b0; bus8.din = 8'h99; bus8.ack_n = 1'b0;
        bus16.ld_n = 1'b0; bus16.din = 16'h1234;
        @(posedge clk);
        #1;
        check("held reset dout",   {24'd0, bus8.dout}, 32'h00);
        check("held reset obf_n",  {31'd0, bus8.obf_n}, 32'd1);
        check("held reset dout16", {16'd0, bus16.dout}, 32'h8001);
        bus8.ld_n = 1'b1; bus8.ack_n = 1'b1; bus16.ld_n = 1'b1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post-reset obf_n", {31'd0, bus8.obf_n}, 32'd1);
        check("post-reset intr",  {31'd0, bus8.intr}, 32'd0);
        check("post-reset dout",  {24'd0, bus8.dout}, 32'h00);

        // 16-bit instance write
        bus16.ld_n = 1'b0; bus16.din = 16'hBEEF;
        @(posedge clk);
        #1;
        bus16.ld_n = 1'b1;
        check("w16 dout", {16'd0, bus16.dout}, 32'hBEEF);
        @(posedge clk);
        #1;
        check("w16 hold", {16'd0, bus16.dout}, 32'hBEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
